// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, control bundle layout and
// forward-select encodings used by the forwarding unit and EX stage.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;

    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_MEM_READ   = 4;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_REG_WRITE  = 6;
    localparam int CTRL_CSR        = 7;
    localparam int CTRL_BRANCH     = 8;
    localparam int CTRL_JUMP       = 9;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG   = 2'b00;
    localparam fwd_sel_t FWD_MEMWB = 2'b01;
    localparam fwd_sel_t FWD_EXMEM = 2'b10;
    localparam fwd_sel_t FWD_MEM2  = 2'b11;

endpackage

// File: rtl/ex_operand_stage_fwd_operand_mux.sv
// Resolves one EX source operand from the held register value or a
// forwarding tap; reads of x0 always yield zero.
module fwd_operand_mux #(
    parameter int XLEN = core_pkg::XLEN
) (
    input  logic [1:0]      sel,
    input  logic [4:0]      reg_addr,
    input  logic [XLEN-1:0] held,
    input  logic [XLEN-1:0] exmem,
    input  logic [XLEN-1:0] mem2,
    input  logic [XLEN-1:0] memwb,
    output logic [XLEN-1:0] operand
);
    import core_pkg::*;

    always_comb begin
        operand = held;
        if (reg_addr == 5'd0) begin
            operand = '0;
        end else begin
            case (sel)
                FWD_MEMWB: operand = memwb;
                FWD_EXMEM: operand = exmem;
                FWD_MEM2:  operand = mem2;
                default:   operand = held;
            endcase
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with forwarded operand resolution and
// stall-time refresh of held operands from active forwarding paths.
module ex_operand_stage #(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int CTRL_W = core_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        forward_a,
    input  logic [1:0]        forward_b,
    input  logic [XLEN-1:0]   exmem_fwd_data,
    input  logic [XLEN-1:0]   mem2_fwd_data,
    input  logic [XLEN-1:0]   memwb_fwd_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [4:0]        ex_rs1_addr,
    output logic [4:0]        ex_rs2_addr,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [31:0]       stall_cycles
);
    import core_pkg::*;

    logic [XLEN-1:0] held_a;
    logic [XLEN-1:0] held_b;

    fwd_operand_mux #(.XLEN(XLEN)) u_mux_a (
        .sel      (forward_a),
        .reg_addr (ex_rs1_addr),
        .held     (held_a),
        .exmem    (exmem_fwd_data),
        .mem2     (mem2_fwd_data),
        .memwb    (memwb_fwd_data),
        .operand  (ex_op_a)
    );

    fwd_operand_mux #(.XLEN(XLEN)) u_mux_b (
        .sel      (forward_b),
        .reg_addr (ex_rs2_addr),
        .held     (held_b),
        .exmem    (exmem_fwd_data),
        .mem2     (mem2_fwd_data),
        .memwb    (memwb_fwd_data),
        .operand  (ex_op_b)
    );

    // While stalled, latching the resolved operand keeps a producer's value
    // after it retires from WB; for x0 the operand is zero either way.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_addr  <= '0;
            ex_rs2_addr  <= '0;
            ex_rd        <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
            held_a       <= '0;
            held_b       <= '0;
            stall_cycles <= '0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_addr  <= '0;
            ex_rs2_addr  <= '0;
            ex_rd        <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
            held_a       <= '0;
            held_b       <= '0;
        end else if (stall) begin
            if (forward_a != FWD_REG) begin
                held_a <= ex_op_a;
            end
            if (forward_b != FWD_REG) begin
                held_b <= ex_op_b;
            end
            if (ex_valid) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_rs1_addr  <= id_rs1_addr;
            ex_rs2_addr  <= id_rs2_addr;
            ex_rd        <= id_rd;
            ex_imm       <= id_imm;
            ex_ctrl      <= id_ctrl;
            held_a       <= id_rs1_data;
            held_b       <= id_rs2_data;
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed pipeline scenarios then
// random traffic, checked against a rule-level reference model.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [4:0]  id_rd;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [15:0] id_ctrl;
    logic        stall;
    logic        flush;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic [31:0] exmem_fwd_data;
    logic [31:0] mem2_fwd_data;
    logic [31:0] memwb_fwd_data;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rs1_addr;
    logic [4:0]  ex_rs2_addr;
    logic [4:0]  ex_rd;
    logic [31:0] ex_imm;
    logic [15:0] ex_ctrl;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [31:0] stall_cycles;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic        stall;
        logic        flush;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] exmem;
        logic [31:0] mem2;
        logic [31:0] memwb;
    } stim_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] cnt;
    } exp_t;

    exp_t expQueue[$];
    int   assertCount = 0;
    int   failCount   = 0;
    bit   stimDone    = 0;

    // Reference model state: what the EX stage should be holding.
    logic        mValid;
    logic [31:0] mPc, mImm, mHeldA, mHeldB, mCnt;
    logic [4:0]  mRs1, mRs2, mRd;
    logic [15:0] mCtrl;

    ex_operand_stage dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_rd          (id_rd),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .id_imm         (id_imm),
        .id_ctrl        (id_ctrl),
        .stall          (stall),
        .flush          (flush),
        .forward_a      (forward_a),
        .forward_b      (forward_b),
        .exmem_fwd_data (exmem_fwd_data),
        .mem2_fwd_data  (mem2_fwd_data),
        .memwb_fwd_data (memwb_fwd_data),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_rs1_addr    (ex_rs1_addr),
        .ex_rs2_addr    (ex_rs2_addr),
        .ex_rd          (ex_rd),
        .ex_imm         (ex_imm),
        .ex_ctrl        (ex_ctrl),
        .ex_op_a        (ex_op_a),
        .ex_op_b        (ex_op_b),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tapValue(input logic [1:0] code, input stim_t s);
        case (code)
            2'b01:   return s.memwb;
            2'b10:   return s.exmem;
            2'b11:   return s.mem2;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] resolve(input logic [4:0] addr, input logic [1:0] code,
                                            input logic [31:0] held, input stim_t s);
        if (addr == 5'd0) return 32'd0;
        if (code == 2'b00) return held;
        return tapValue(code, s);
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Drive one cycle of inputs at the falling edge, advance the model and
    // queue what the DUT should show just after the following rising edge.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst = s.rst; id_valid = s.valid; id_pc = s.pc;
        id_rs1_addr = s.rs1; id_rs2_addr = s.rs2; id_rd = s.rd;
        id_rs1_data = s.d1; id_rs2_data = s.d2; id_imm = s.imm; id_ctrl = s.ctrl;
        stall = s.stall; flush = s.flush; forward_a = s.fa; forward_b = s.fb;
        exmem_fwd_data = s.exmem; mem2_fwd_data = s.mem2; memwb_fwd_data = s.memwb;

        if (s.rst) begin
            mValid = 0; mPc = 0; mRs1 = 0; mRs2 = 0; mRd = 0; mImm = 0; mCtrl = 0;
            mHeldA = 0; mHeldB = 0; mCnt = 0;
        end else if (s.flush) begin
            mValid = 0; mPc = 0; mRs1 = 0; mRs2 = 0; mRd = 0; mImm = 0; mCtrl = 0;
            mHeldA = 0; mHeldB = 0;
        end else if (s.stall) begin
            if (mValid) mCnt = mCnt + 1;
            if (s.fa != 2'b00) mHeldA = tapValue(s.fa, s);
            if (s.fb != 2'b00) mHeldB = tapValue(s.fb, s);
        end else begin
            mValid = s.valid; mPc = s.pc; mRs1 = s.rs1; mRs2 = s.rs2; mRd = s.rd;
            mImm = s.imm; mCtrl = s.ctrl; mHeldA = s.d1; mHeldB = s.d2;
        end

        e.valid = mValid; e.pc = mPc; e.rs1 = mRs1; e.rs2 = mRs2; e.rd = mRd;
        e.imm = mImm; e.ctrl = mCtrl; e.cnt = mCnt;
        e.op_a = resolve(mRs1, s.fa, mHeldA, s);
        e.op_b = resolve(mRs2, s.fb, mHeldB, s);
        expQueue.push_back(e);
    endtask

    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] req);
        assertCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
        compareField("ex_pc", ex_pc, e.pc);
        compareField("ex_rs1_addr", {27'd0, ex_rs1_addr}, {27'd0, e.rs1});
        compareField("ex_rs2_addr", {27'd0, ex_rs2_addr}, {27'd0, e.rs2});
        compareField("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
        compareField("ex_imm", ex_imm, e.imm);
        compareField("ex_ctrl", {16'd0, ex_ctrl}, {16'd0, e.ctrl});
        compareField("ex_op_a", ex_op_a, e.op_a);
        compareField("ex_op_b", ex_op_b, e.op_b);
        compareField("stall_cycles", stall_cycles, e.cnt);
    endtask

    // Monitor: every rising edge the DUT presents a new EX state to check.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQueue.size() > 0) checkOutput(expQueue.pop_front());
        end
    end

    initial begin
        stim_t s;
        rst = 1; id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_ctrl = 0; stall = 0; flush = 0;
        forward_a = 0; forward_b = 0; exmem_fwd_data = 0; mem2_fwd_data = 0; memwb_fwd_data = 0;

        $display("[TB] reset then advance");
        s = idleStim(); s.rst = 1;
        applyStimulus(s);
        applyStimulus(s);
        s = idleStim(); s.valid = 1; s.pc = 32'h100; s.rs1 = 5'd1; s.d1 = 32'd5;
        s.rd = 5'd2; s.ctrl = 16'h0041; s.imm = 32'h10;
        applyStimulus(s);

        $display("[TB] forward select and x0 guard");
        s = idleStim(); s.valid = 1; s.pc = 32'h104; s.rs1 = 5'd3; s.rs2 = 5'd0;
        s.d1 = 32'h77; s.d2 = 32'h99; s.ctrl = 16'h0042; s.rd = 5'd4;
        s.exmem = 32'hAA; s.mem2 = 32'hBB; s.memwb = 32'hCC;
        applyStimulus(s);
        s.stall = 1;
        s.fb = 2'b10; s.exmem = 32'hDEAD;
        s.fa = 2'b10; applyStimulus(s);
        s.exmem = 32'hAA;
        s.fa = 2'b11; applyStimulus(s);
        s.fa = 2'b01; applyStimulus(s);
        s.fa = 2'b00; s.fb = 2'b00; applyStimulus(s);

        $display("[TB] load-use stall with refresh");
        s = idleStim(); s.valid = 1; s.pc = 32'h200; s.rs1 = 5'd5; s.rs2 = 5'd6;
        s.d1 = 32'h1; s.d2 = 32'h2; s.rd = 5'd7; s.ctrl = 16'h0043;
        applyStimulus(s);
        s.stall = 1; s.valid = 0; s.pc = 32'h204;
        applyStimulus(s);
        s.memwb = 32'h1234; s.fa = 2'b01;
        applyStimulus(s);
        s.memwb = 32'h0; s.fa = 2'b00;
        applyStimulus(s);

        $display("[TB] flush over stall");
        s.stall = 1; s.flush = 1;
        applyStimulus(s);

        $display("[TB] reset mid-stall");
        s = idleStim(); s.valid = 1; s.pc = 32'h300; s.rs1 = 5'd8; s.rs2 = 5'd9;
        s.d1 = 32'h11; s.d2 = 32'h22; s.ctrl = 16'h0100;
        applyStimulus(s);
        s.stall = 1; s.fb = 2'b11; s.mem2 = 32'h5555;
        applyStimulus(s);
        s.rst = 1;
        applyStimulus(s);
        s = idleStim();
        applyStimulus(s);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            s.rst   = ($urandom_range(0, 99) < 2);
            s.valid = $urandom_range(0, 1);
            s.pc    = $urandom;
            s.rs1   = 5'($urandom_range(0, 7));
            s.rs2   = 5'($urandom_range(0, 7));
            s.rd    = 5'($urandom);
            s.d1    = $urandom;
            s.d2    = $urandom;
            s.imm   = $urandom;
            s.ctrl  = 16'($urandom);
            s.stall = ($urandom_range(0, 99) < 35);
            s.flush = ($urandom_range(0, 99) < 10);
            s.fa    = 2'($urandom);
            s.fb    = 2'($urandom);
            s.exmem = $urandom;
            s.mem2  = $urandom;
            s.memwb = $urandom;
            applyStimulus(s);
        end

        stimDone = 1;
        repeat (3) @(posedge clk);
        #2;
        assertCount++;
        if (expQueue.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQueue.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
